// File: rtl/ramb4_s16_port_arbiter.sv
// B-port sequencer for a RAMB4_S4_S16: zero-fill, then round-robin
// single-word access for two requesters with registered read return.
module ramb4_s16_port_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] FILL_VALUE     = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CLR,
  output logic        BUSY,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [7:0]  ADDR0,
  input  logic [7:0]  ADDR1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic [15:0] RDATA0,
  output logic [15:0] RDATA1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic        ENB,
  output logic        WEB,
  output logic [7:0]  ADDRB,
  output logic [15:0] DIB,
  output logic        RSTB,
  input  logic [15:0] DOB
);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ptr;
  logic        ptr_nxt;
  logic [7:0]  fcnt;
  logic [7:0]  fcnt_nxt;
  logic        acc;
  logic        sel;
  logic        sel_we;
  logic        rd1_v;
  logic        rd1_id;
  logic        rd2_v;
  logic        rd2_id;

  assign RSTB   = 1'b0;
  assign BUSY   = (state == ST_CLEAR);
  assign acc    = GNT0 | GNT1;
  assign sel    = GNT1;
  assign sel_we = sel ? WE1 : WE0;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    ptr_nxt   = ptr;
    GNT0      = 1'b0;
    GNT1      = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        fcnt_nxt = fcnt + 8'd1;
        if (fcnt == 8'hFF)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        GNT0 = REQ0 & (~REQ1 | ~ptr);
        GNT1 = REQ1 & (~REQ0 | ptr);
        if (GNT0)
          ptr_nxt = 1'b1;
        else if (GNT1)
          ptr_nxt = 1'b0;
        if (CLR) begin
          state_nxt = ST_CLEAR;
          fcnt_nxt  = 8'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      fcnt  <= 8'd0;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ENB   <= 1'b0;
      WEB   <= 1'b0;
      ADDRB <= 8'd0;
      DIB   <= 16'd0;
    end else if (state == ST_CLEAR) begin
      ENB   <= 1'b1;
      WEB   <= 1'b1;
      ADDRB <= fcnt;
      DIB   <= FILL_VALUE;
    end else if (acc) begin
      ENB   <= 1'b1;
      WEB   <= sel_we;
      ADDRB <= sel ? ADDR1 : ADDR0;
      DIB   <= sel ? WDATA1 : WDATA0;
    end else begin
      ENB   <= 1'b0;
      WEB   <= 1'b0;
    end
  end

  // read tag follows the access to the RAM edge, then to DOB capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd1_v   <= 1'b0;
      rd1_id  <= 1'b0;
      rd2_v   <= 1'b0;
      rd2_id  <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA0  <= 16'd0;
      RDATA1  <= 16'd0;
    end else begin
      rd1_v   <= acc & ~sel_we;
      rd1_id  <= sel;
      rd2_v   <= rd1_v;
      rd2_id  <= rd1_id;
      RVALID0 <= rd2_v & ~rd2_id;
      RVALID1 <= rd2_v & rd2_id;
      if (rd2_v & ~rd2_id)
        RDATA0 <= DOB;
      if (rd2_v & rd2_id)
        RDATA1 <= DOB;
    end
  end

endmodule

// File: tb/tb_ramb4_s16_port_arbiter.sv
// Bench for ramb4_s16_port_arbiter: RAM model, reference scoreboard,
// directed steps and a randomized phase.
module tb_ramb4_s16_port_arbiter;

  localparam logic [15:0] FILL = 16'h0000;

  logic clk;
  logic rst_n;
  logic clr;
  logic busy;
  logic req0, req1, we0, we1;
  logic [7:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic gnt0, gnt1;
  logic [15:0] rdata0, rdata1;
  logic rvalid0, rvalid1;
  logic enb, web, rstb;
  logic [7:0] addrb;
  logic [15:0] dib, dob;

  logic busy_b, gnt0_b, gnt1_b, rv0_b, rv1_b;
  logic enb_b, web_b, rstb_b;
  logic req1_b;
  logic [7:0] addrb_b;
  logic [15:0] rd0_b, rd1_b, dib_b;

  ramb4_s16_port_arbiter #(
    .CLEAR_ON_RESET(1'b1),
    .FILL_VALUE(FILL)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .BUSY(busy),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .ADDR0(addr0), .ADDR1(addr1),
    .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT0(gnt0), .GNT1(gnt1),
    .RDATA0(rdata0), .RDATA1(rdata1),
    .RVALID0(rvalid0), .RVALID1(rvalid1),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib),
    .RSTB(rstb), .DOB(dob)
  );

  ramb4_s16_port_arbiter #(
    .CLEAR_ON_RESET(1'b0),
    .FILL_VALUE(16'h1234)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .BUSY(busy_b),
    .REQ0(1'b0), .REQ1(req1_b), .WE0(1'b0), .WE1(1'b0),
    .ADDR0(8'h00), .ADDR1(8'h5A),
    .WDATA0(16'h0), .WDATA1(16'h0),
    .GNT0(gnt0_b), .GNT1(gnt1_b),
    .RDATA0(rd0_b), .RDATA1(rd1_b),
    .RVALID0(rv0_b), .RVALID1(rv1_b),
    .ENB(enb_b), .WEB(web_b), .ADDRB(addrb_b), .DIB(dib_b),
    .RSTB(rstb_b), .DOB(16'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // block RAM model, write-first
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  always @(posedge clk) begin
    if (enb) begin
      if (web) begin
        mem[addrb] <= dib;
        dob <= dib;
      end else begin
        dob <= mem[addrb];
      end
    end
  end

  typedef struct {
    int          due;
    bit          id;
    logic [15:0] d;
  } rd_t;

  int nvec = 0;
  int nerr = 0;
  int cnt = 0;
  int busy_left;
  bit ptr_m;
  bit g0, g1;
  logic [15:0] refmem [256];
  rd_t q[$];
  logic exp_en, exp_we;
  logic [7:0] exp_addr;
  logic [15:0] exp_dib;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr_m = 1'b0;
    busy_left = 256;
    for (int i = 0; i < 256; i++) refmem[i] = FILL;
  endtask

  // one clock cycle: check at negedge, advance model, return after posedge
  task automatic cyc();
    bit bm, ev0, ev1;
    @(negedge clk);
    if (!rst_n) model_reset();
    bm = (busy_left > 0);
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n && !bm) begin
      if (req0 && (!req1 || !ptr_m)) g0 = 1'b1;
      else if (req1) g1 = 1'b1;
    end
    chk("busy", busy, bm);
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("rstb", rstb, 1'b0);
    if (!rst_n) begin
      chk("rst_enb", enb, 0);
      chk("rst_web", web, 0);
      chk("rst_addrb", addrb, 0);
      chk("rst_dib", dib, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
    end else begin
      chk("enb", enb, exp_en);
      chk("web", web, exp_we);
      if (exp_en) chk("addrb", addrb, exp_addr);
      if (exp_en && exp_we) chk("dib", dib, exp_dib);
    end
    ev0 = q.size() > 0 && q[0].due == cnt && q[0].id == 1'b0;
    ev1 = q.size() > 0 && q[0].due == cnt && q[0].id == 1'b1;
    chk("rvalid0", rvalid0, ev0);
    chk("rvalid1", rvalid1, ev1);
    if (ev0) chk("rdata0", rdata0, q[0].d);
    if (ev1) chk("rdata1", rdata1, q[0].d);
    if (ev0 || ev1) void'(q.pop_front());
    if (!rst_n) begin
      exp_en = 0; exp_we = 0; exp_addr = 0; exp_dib = 0;
    end else if (bm) begin
      exp_en = 1;
      exp_we = 1;
      exp_addr = 8'(256 - busy_left);
      exp_dib = FILL;
      busy_left--;
    end else begin
      if (g0 || g1) begin
        ptr_m = g0;
        exp_en = 1;
        exp_we = g1 ? we1 : we0;
        exp_addr = g1 ? addr1 : addr0;
        exp_dib = g1 ? wdata1 : wdata0;
        if (exp_we) refmem[exp_addr] = exp_dib;
        else q.push_back('{cnt + 3, g1, refmem[exp_addr]});
      end else begin
        exp_en = 0;
        exp_we = 0;
      end
      if (clr) begin
        busy_left = 256;
        for (int i = 0; i < 256; i++) refmem[i] = FILL;
      end
    end
    cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input bit we, input logic [7:0] a,
                       input logic [15:0] d);
    bit done;
    done = 1'b0;
    if (!id) begin
      req0 = 1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1; we1 = we; addr1 = a; wdata1 = d;
    end
    for (int k = 0; k < 300 && !done; k++) begin
      cyc();
      done = id ? g1 : g0;
    end
    chk("issue_done", done, 1'b1);
    if (!id) req0 = 0;
    else req1 = 0;
  endtask

  initial begin
    rst_n = 0; clr = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    req1_b = 0;
    exp_en = 0; exp_we = 0; exp_addr = 0; exp_dib = 0;
    model_reset();
    cyc();
    chk("b_busy_rst", busy_b, 1'b0);
    rst_n = 1;
    req1_b = 1;
    #2;
    chk("b_busy", busy_b, 1'b0);
    chk("b_gnt1", gnt1_b, 1'b1);
    cyc();
    chk("b_enb", enb_b, 1'b1);
    chk("b_addrb", addrb_b, 8'h5A);
    req1_b = 0;
    repeat (256) cyc();
    chk("fill_done", busy, 1'b0);

    issue(0, 0, 8'h7F, 16'h0);
    issue(0, 1, 8'h12, 16'hA5C3);
    issue(0, 0, 8'h12, 16'h0);
    repeat (4) cyc();

    issue(0, 1, 8'h20, 16'h1111);
    issue(1, 1, 8'h21, 16'h2222);
    req0 = 1; we0 = 0; addr0 = 8'h20;
    req1 = 1; we1 = 0; addr1 = 8'h21;
    repeat (6) begin
      cyc();
      if (g0) addr0 = addr0 ^ 8'h01;
      if (g1) addr1 = addr1 ^ 8'h01;
    end
    req0 = 0; req1 = 0;
    repeat (4) cyc();

    issue(0, 0, 8'h20, 16'h0);
    issue(1, 0, 8'h21, 16'h0);
    clr = 1;
    cyc();
    clr = 0;
    repeat (257) cyc();
    issue(1, 0, 8'h20, 16'h0);
    repeat (4) cyc();

    for (int i = 0; i < 400; i++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1; we0 = 1'($urandom);
        addr0 = 8'h40 + 8'($urandom_range(0, 3));
        wdata0 = 16'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1; we1 = 1'($urandom);
        addr1 = 8'h40 + 8'($urandom_range(0, 3));
        wdata1 = 16'($urandom);
      end
      clr = ($urandom_range(0, 149) == 0);
      cyc();
      clr = 0;
      if (g0) req0 = 0;
      if (g1) req1 = 0;
    end
    req0 = 0; req1 = 0;
    repeat (300) cyc();

    clr = 1;
    cyc();
    clr = 0;
    repeat (101) cyc();
    chk("mid_fill_addr", addrb, 8'd100);
    rst_n = 0;
    #1;
    chk("async_enb", enb, 1'b0);
    chk("async_addrb", addrb, 8'd0);
    repeat (2) cyc();
    rst_n = 1;
    repeat (258) cyc();

    issue(0, 0, 8'h7F, 16'h0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    repeat (262) cyc();
    issue(1, 0, 8'h7F, 16'h0);
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
